huffman_merge_writer: RTL and testbench

- Consumer and write-back end of the two-minimum selection path in the Huffman tree build.
- Accepts one selected pair per transfer: min1/min2 weights with 8-bit slot addresses, where addr[0]=0 marks the lower bank pair and addr[0]=1 marks the upper bank pair.
- Writes the merged weight back into the min1 slot and zeroes the min2 slot, so the selector skips it from then on.
- Emits one tree-link record per merge and counts merges until one nonzero node remains.

---
 rtl/huffman_merge_writer.sv | 110 +++++++++++
 tb/tb_huffman_merge_writer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/huffman_merge_writer.sv
// Write-back end of the Huffman two-minimum path: merges a selected pair into the min1 slot and clears min2.
// Sum write lands 1 cycle after transfer, the clear 2 cycles after; in_ready is low for the 2 write cycles.
module huffman_merge_writer #(
   parameter int W  = 11,
   parameter int AW = 8,
   parameter int CW = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [CW-1:0] num_active,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  min1,
   input  logic [W-1:0]  min2,
   input  logic [AW-1:0] min1_addr,
   input  logic [AW-1:0] min2_addr,
   output logic          wmem_en,
   output logic [AW-1:0] wmem_addr,
   output logic [W-1:0]  wmem_data,
   output logic          link_valid,
   output logic [AW-1:0] link_left,
   output logic [AW-1:0] link_right,
   output logic [W-1:0]  link_sum,
   output logic          busy,
   output logic          done,
   output logic          ovf,
   output logic          err
);

   typedef enum logic [2:0] {IDLE, WAIT, WR_SUM, WR_CLR, DONE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] remaining;
   logic [CW-1:0] rem_dec;
   logic [AW-1:0] left_q, right_q;
   logic [W-1:0]  sum_q;
   logic          ovf_q, err_q;

   logic          xfer;
   logic          illegal;
   logic          build_ok;
   logic [W:0]    sum_full;

   assign xfer     = in_valid && (state == WAIT);
   assign illegal  = (min1 == '0) || (min2 == '0) || (min1_addr == min2_addr);
   assign build_ok = (num_active >= CW'(2));
   assign sum_full = {1'b0, min1} + {1'b0, min2};
   assign rem_dec  = remaining - CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = build_ok ? WAIT : DONE;
         WAIT:    if (xfer && !illegal) state_nx = WR_SUM;
         WR_SUM:  state_nx = WR_CLR;
         WR_CLR:  state_nx = (rem_dec == CW'(1)) ? DONE : WAIT;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Dropped pairs only flag err; nothing is latched so a pending merge is never disturbed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= '0;
         left_q    <= '0;
         right_q   <= '0;
         sum_q     <= '0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (state == IDLE && start && build_ok) begin
            remaining <= num_active;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
         end
         if (xfer) begin
            if (illegal) begin
               err_q <= 1'b1;
            end else begin
               left_q  <= min1_addr;
               right_q <= min2_addr;
               sum_q   <= sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
               if (sum_full[W]) ovf_q <= 1'b1;
            end
         end
         if (state == WR_CLR) remaining <= rem_dec;
      end
   end

   assign in_ready   = (state == WAIT);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign wmem_en    = (state == WR_SUM) || (state == WR_CLR);
   assign wmem_addr  = (state == WR_SUM) ? left_q : (state == WR_CLR) ? right_q : '0;
   assign wmem_data  = (state == WR_SUM) ? sum_q : '0;
   assign link_valid = (state == WR_SUM);
   assign link_left  = (state == WR_SUM) ? left_q : '0;
   assign link_right = (state == WR_SUM) ? right_q : '0;
   assign link_sum   = (state == WR_SUM) ? sum_q : '0;
   assign ovf        = ovf_q;
   assign err        = err_q;

endmodule

// File: tb/tb_huffman_merge_writer.sv
// Scoreboard bench for huffman_merge_writer: directed pairs push expected writes/links/dones,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_huffman_merge_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [8:0]  num_active = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [10:0] min1 = '0, min2 = '0;
   logic [7:0]  min1_addr = '0, min2_addr = '0;
   logic        wmem_en;
   logic [7:0]  wmem_addr;
   logic [10:0] wmem_data;
   logic        link_valid;
   logic [7:0]  link_left, link_right;
   logic [10:0] link_sum;
   logic        busy, done, ovf, err;

   huffman_merge_writer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_active(num_active),
      .in_valid(in_valid), .in_ready(in_ready), .min1(min1), .min2(min2),
      .min1_addr(min1_addr), .min2_addr(min2_addr),
      .wmem_en(wmem_en), .wmem_addr(wmem_addr), .wmem_data(wmem_data),
      .link_valid(link_valid), .link_left(link_left), .link_right(link_right),
      .link_sum(link_sum), .busy(busy), .done(done), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [7:0] addr; logic [10:0] data; int c; } wr_t;
   typedef struct { logic [7:0] l; logic [7:0] r; logic [10:0] s; } lk_t;

   wr_t wq[$];
   lk_t lq[$];
   int  dq[$];

   int n_chk  = 0;
   int n_pass = 0;

   function automatic void chk(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endfunction

   always @(negedge clk) begin
      if (wmem_en) begin
         if (wq.size() == 0) chk("unexpected_write", int'(wmem_en), 0);
         else begin
            wr_t e;
            e = wq.pop_front();
            chk("wr_addr", int'(wmem_addr), int'(e.addr));
            chk("wr_data", int'(wmem_data), int'(e.data));
            chk("wr_cycle", cyc, e.c);
         end
      end
      if (link_valid) begin
         if (lq.size() == 0) chk("unexpected_link", int'(link_valid), 0);
         else begin
            lk_t e;
            e = lq.pop_front();
            chk("link_left", int'(link_left), int'(e.l));
            chk("link_right", int'(link_right), int'(e.r));
            chk("link_sum", int'(link_sum), int'(e.s));
         end
      end
      if (done) begin
         if (dq.size() == 0) chk("unexpected_done", int'(done), 0);
         else chk("done_cycle", cyc, dq.pop_front());
      end
   end

   task automatic do_start(input int n);
      @(negedge clk);
      start = 1'b1;
      num_active = 9'(n);
      if (n < 2 && !busy) dq.push_back(cyc + 1);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send(input logic [10:0] m1, input logic [10:0] m2,
                       input logic [7:0] a1, input logic [7:0] a2,
                       input bit legal, input logic [10:0] esum,
                       input bit last, input bit push, output int tc);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      min1 = m1; min2 = m2; min1_addr = a1; min2_addr = a2;
      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("in_ready_timeout", int'(in_ready), 1);
      tc = cyc + 1;
      if (push && legal) begin
         wq.push_back('{addr: a1, data: esum, c: tc});
         wq.push_back('{addr: a2, data: 11'd0, c: tc + 1});
         lq.push_back('{l: a1, r: a2, s: esum});
         if (last) dq.push_back(tc + 2);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", int'(busy), 0);
   endtask

   initial begin
      int t1, t2, t3;
      #2;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_wmem_en", int'(wmem_en), 0);
      chk("rst_link_valid", int'(link_valid), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_wmem_addr", int'(wmem_addr), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // basic two-leaf merge
      do_start(2);
      chk("busy_after_start", int'(busy), 1);
      send(11'd5, 11'd7, 8'h04, 8'h0B, 1, 11'd12, 1, 1, t1);
      wait_idle();
      chk("t2_ovf", int'(ovf), 0);

      // four leaves, in_valid held high across pairs
      do_start(4);
      send(11'd1, 11'd2, 8'h00, 8'h01, 1, 11'd3, 0, 1, t1);
      send(11'd3, 11'd3, 8'h00, 8'h03, 1, 11'd6, 0, 1, t2);
      send(11'd4, 11'd6, 8'h02, 8'h00, 1, 11'd10, 1, 1, t3);
      wait_idle();
      chk("spacing_1_2", t2 - t1, 3);
      chk("spacing_2_3", t3 - t2, 3);

      // saturation
      do_start(2);
      send(11'd2000, 11'd100, 8'h20, 8'h21, 1, 11'd2047, 1, 1, t1);
      chk("ovf_set", int'(ovf), 1);
      wait_idle();
      chk("ovf_sticky", int'(ovf), 1);

      // illegal pairs then a legal one
      do_start(2);
      chk("ovf_cleared", int'(ovf), 0);
      chk("err_clear", int'(err), 0);
      send(11'd5, 11'd0, 8'h30, 8'h31, 0, 11'd0, 0, 1, t1);
      chk("err_min2_zero", int'(err), 1);
      chk("stay_wait", int'(in_ready), 1);
      send(11'd5, 11'd5, 8'h10, 8'h10, 0, 11'd0, 0, 1, t1);
      chk("err_same_addr", int'(err), 1);
      send(11'd9, 11'd4, 8'h30, 8'h31, 1, 11'd13, 1, 1, t1);
      wait_idle();
      chk("err_sticky", int'(err), 1);

      // num_active=1 and a start while busy
      do_start(1);
      wait_idle();
      do_start(3);
      do_start(2);
      send(11'd3, 11'd4, 8'h40, 8'h41, 1, 11'd7, 0, 1, t1);
      send(11'd7, 11'd8, 8'h40, 8'h42, 1, 11'd15, 1, 1, t2);
      wait_idle();

      // reset asserted during the sum write
      do_start(2);
      send(11'd5, 11'd7, 8'h04, 8'h0B, 1, 11'd12, 1, 0, t1);
      chk("pre_rst_wmem_en", int'(wmem_en), 1);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_wmem_en", int'(wmem_en), 0);
      chk("arst_in_ready", int'(in_ready), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_link_valid", int'(link_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_in_ready", int'(in_ready), 0);

      repeat (3) @(negedge clk);
      chk("wq_drained", wq.size(), 0);
      chk("lq_drained", lq.size(), 0);
      chk("dq_drained", dq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
